// File: rtl/m_dm_access_ctrl.sv
// Memory-stage data-memory access controller: decodes the M-stage load/store into a
// word-aligned bus transaction, stalls until the slave answers, and captures the raw read word.
module m_dm_access_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Valid,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [2:0]  DMReadEN,
    input  logic [2:0]  DMWriteEN,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [31:0] DM_RD_raw,
    output logic        Stall,
    output logic        AdEL,
    output logic        AdES,
    output logic        Timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    byteen_q, byteen_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   raw_q, raw_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          isWrite;
    logic [2:0]    code;
    logic          live;
    logic          misaligned;
    logic [3:0]    decByteen;
    logic [31:0]   decWdata;

    // A write request overrides any read enable; only codes 1..3 describe a real access.
    always_comb begin
        isWrite    = (DMWriteEN != 3'd0);
        code       = isWrite ? DMWriteEN : DMReadEN;
        live       = Valid && (code == 3'd1 || code == 3'd2 || code == 3'd3);
        misaligned = ((code == 3'd1) && (Addr[1:0] != 2'b00)) ||
                     ((code == 3'd2) && Addr[0]);
        decByteen  = 4'b0000;
        decWdata   = 32'h0;
        case (code)
            3'd1: begin
                decByteen = 4'b1111;
                decWdata  = WD;
            end
            3'd2: begin
                decByteen = Addr[1] ? 4'b1100 : 4'b0011;
                decWdata  = {2{WD[15:0]}};
            end
            3'd3: begin
                decByteen = 4'b0001 << Addr[1:0];
                decWdata  = {4{WD[7:0]}};
            end
            default: begin
                decByteen = 4'b0000;
                decWdata  = 32'h0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        raw_d    = raw_q;
        cnt_d    = cnt_q;
        Stall    = 1'b0;
        AdEL     = 1'b0;
        AdES     = 1'b0;
        Timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (live && misaligned) begin
                    AdEL = !isWrite;
                    AdES = isWrite;
                end else if (live) begin
                    Stall    = 1'b1;
                    req_d    = 1'b1;
                    wr_d     = isWrite;
                    addr_d   = {Addr[31:2], 2'b00};
                    byteen_d = isWrite ? decByteen : 4'b0000;
                    wdata_d  = isWrite ? decWdata : 32'h0;
                    cnt_d    = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                Stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // A response in the last allowed cycle still completes normally.
                if (m_ready) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!wr_q) begin
                        raw_d = m_rdata;
                    end
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    req_d   = 1'b0;
                    Timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 32'h0;
            byteen_q <= 4'b0000;
            wdata_q  <= 32'h0;
            raw_q    <= 32'h0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            raw_q    <= raw_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_req     = req_q;
    assign m_wr      = wr_q;
    assign m_addr    = addr_q;
    assign m_byteen  = byteen_q;
    assign m_wdata   = wdata_q;
    assign DM_RD_raw = raw_q;

endmodule

// File: tb/tb_m_dm_access_ctrl.sv
// Self-checking bench for m_dm_access_ctrl: a transaction-level model sets per-cycle
// expectations that one negedge process compares, plus literal checks on key scenarios.
module tb_m_dm_access_ctrl;

   localparam int MAX_WAIT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        Valid;
   logic [31:0] Addr;
   logic [31:0] WD;
   logic [2:0]  DMReadEN;
   logic [2:0]  DMWriteEN;
   logic        m_req;
   logic        m_wr;
   logic [31:0] m_addr;
   logic [3:0]  m_byteen;
   logic [31:0] m_wdata;
   logic        m_ready;
   logic [31:0] m_rdata;
   logic [31:0] DM_RD_raw;
   logic        Stall;
   logic        AdEL;
   logic        AdES;
   logic        Timeout;

   int checks = 0;
   int failures = 0;
   bit checkOn = 1'b0;

   bit          expStall, expAdEL, expAdES, expTimeout, expReq, expWr;
   logic [31:0] expAddr, expWdata, expRaw;
   logic [3:0]  expByteen;
   logic [31:0] modelRaw;

   int          stallCnt, toCnt;
   logic [31:0] seenAddr, seenWdata;
   logic [3:0]  seenByteen;
   logic        seenWr;

   m_dm_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .Valid(Valid), .Addr(Addr), .WD(WD),
      .DMReadEN(DMReadEN), .DMWriteEN(DMWriteEN),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_byteen(m_byteen),
      .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
      .DM_RD_raw(DM_RD_raw), .Stall(Stall), .AdEL(AdEL), .AdES(AdES), .Timeout(Timeout)
   );

   // Free-running clock; all stimulus changes 1ns after a rising edge.
   always #5 clk = ~clk;

   // Single comparison point used by both the per-cycle process and the literal checks.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Lane rules for the bus: which bytes a store touches and how its data is replicated.
   function automatic logic [3:0] modelByteen(input logic [2:0] code, input logic [31:0] a);
      case (code)
         3'd1:    return 4'b1111;
         3'd2:    return a[1] ? 4'b1100 : 4'b0011;
         3'd3:    return 4'b0001 << a[1:0];
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] code, input logic [31:0] d);
      case (code)
         3'd1:    return d;
         3'd2:    return {d[15:0], d[15:0]};
         3'd3:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
         default: return 32'h0;
      endcase
   endfunction

   // Compare every cycle on the falling edge, well away from the rising edge.
   always @(negedge clk) begin
      if (checkOn) begin
         checkOutput("Stall", 32'(Stall), 32'(expStall));
         checkOutput("AdEL", 32'(AdEL), 32'(expAdEL));
         checkOutput("AdES", 32'(AdES), 32'(expAdES));
         checkOutput("Timeout", 32'(Timeout), 32'(expTimeout));
         checkOutput("m_req", 32'(m_req), 32'(expReq));
         checkOutput("DM_RD_raw", DM_RD_raw, expRaw);
         if (expReq) begin
            checkOutput("m_wr", 32'(m_wr), 32'(expWr));
            checkOutput("m_addr", m_addr, expAddr);
            checkOutput("m_byteen", 32'(m_byteen), 32'(expByteen));
            checkOutput("m_wdata", m_wdata, expWdata);
         end
         if (Stall) stallCnt++;
         if (Timeout) toCnt++;
      end
   end

   task automatic setIdleExpect();
      expStall   = 1'b0;
      expAdEL    = 1'b0;
      expAdES    = 1'b0;
      expTimeout = 1'b0;
      expReq     = 1'b0;
      expRaw     = modelRaw;
   endtask

   // One M-stage instruction. waitCycles = REQ cycles before m_ready (-1: slave never answers).
   task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] rd, input logic [2:0] wr,
                                input int waitCycles, input logic [31:0] rdata);
      bit         isW, live, mis;
      logic [2:0] code;
      isW  = (wr != 3'd0);
      code = isW ? wr : rd;
      live = v && (code >= 3'd1) && (code <= 3'd3);
      mis  = live && (((code == 3'd1) && (a[1:0] != 2'b00)) || ((code == 3'd2) && a[0]));
      stallCnt = 0;
      toCnt    = 0;
      Valid = v; Addr = a; WD = wd; DMReadEN = rd; DMWriteEN = wr;
      m_ready = 1'b0; m_rdata = 32'h0BAD0BAD;
      setIdleExpect();
      expStall = live && !mis;
      expAdEL  = mis && !isW;
      expAdES  = mis && isW;
      @(posedge clk); #1;
      if (live && !mis) begin
         expReq    = 1'b1;
         expWr     = isW;
         expAddr   = {a[31:2], 2'b00};
         expByteen = isW ? modelByteen(code, a) : 4'b0000;
         expWdata  = isW ? modelWdata(code, wd) : 32'h0;
         expAdEL   = 1'b0;
         expAdES   = 1'b0;
         expStall  = 1'b1;
         // Inputs changing during the transaction must not disturb it or raise AdES.
         Valid = 1'b1; Addr = 32'h0000_0007; WD = 32'hFFFF_FFFF;
         DMReadEN = 3'd1; DMWriteEN = 3'd1;
         seenAddr = m_addr; seenByteen = m_byteen; seenWdata = m_wdata; seenWr = m_wr;
         for (int k = 1; k <= MAX_WAIT; k++) begin
            bit rdy;
            rdy = (k == waitCycles + 1);
            m_ready = rdy;
            m_rdata = rdy ? rdata : 32'hFFFF_0000;
            expTimeout = !rdy && (k == MAX_WAIT);
            @(posedge clk); #1;
            if (rdy && !isW) modelRaw = rdata;
            if (rdy) break;
         end
         // DONE cycle: a stray m_ready here must be ignored.
         setIdleExpect();
         m_ready = 1'b1; m_rdata = 32'h5555_5555;
         @(posedge clk); #1;
      end
      m_ready = 1'b0; Valid = 1'b0; DMReadEN = 3'd0; DMWriteEN = 3'd0;
      setIdleExpect();
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      Valid = 1'b0; Addr = 32'h0; WD = 32'h0; DMReadEN = 3'd0; DMWriteEN = 3'd0;
      m_ready = 1'b0; m_rdata = 32'h0;
      modelRaw = 32'h0;
      stallCnt = 0; toCnt = 0;
      setIdleExpect();
      expWr = 1'b0; expAddr = 32'h0; expByteen = 4'b0; expWdata = 32'h0;
      checkOn = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // lw 0x100, immediate response
      applyStimulus(1'b1, 32'h100, 32'h0, 3'd1, 3'd0, 0, 32'hDEAD_BEEF);
      checkOutput("lw_raw_lit", DM_RD_raw, 32'hDEAD_BEEF);
      checkOutput("lw_addr_lit", seenAddr, 32'h100);
      checkOutput("lw_byteen_lit", 32'(seenByteen), 32'h0);
      checkOutput("lw_stall_lit", 32'(stallCnt), 32'd2);

      // sb 0x203
      applyStimulus(1'b1, 32'h203, 32'h0000_00A5, 3'd0, 3'd3, 0, 32'h0);
      checkOutput("sb_addr_lit", seenAddr, 32'h200);
      checkOutput("sb_byteen_lit", 32'(seenByteen), 32'h8);
      checkOutput("sb_wdata_lit", seenWdata, 32'hA5A5_A5A5);
      checkOutput("sb_wr_lit", 32'(seenWr), 32'h1);
      checkOutput("sb_raw_kept_lit", DM_RD_raw, 32'hDEAD_BEEF);

      // sh 0x102, slave waits 3 cycles
      applyStimulus(1'b1, 32'h102, 32'h0000_1234, 3'd0, 3'd2, 3, 32'h0);
      checkOutput("sh_byteen_lit", 32'(seenByteen), 32'hC);
      checkOutput("sh_wdata_lit", seenWdata, 32'h1234_1234);
      checkOutput("sh_stall_lit", 32'(stallCnt), 32'd5);

      // Misaligned accesses
      applyStimulus(1'b1, 32'h101, 32'h0, 3'd1, 3'd0, 0, 32'h0);
      applyStimulus(1'b1, 32'h003, 32'hCAFE, 3'd0, 3'd2, 0, 32'h0);
      checkOutput("misaligned_stall_lit", 32'(stallCnt), 32'd0);

      // Further aligned patterns, write overriding read, no-op codes, Valid low
      applyStimulus(1'b1, 32'h0000_1006, 32'h0, 3'd2, 3'd0, 1, 32'h1357_9BDF);
      applyStimulus(1'b1, 32'h0000_2001, 32'h0, 3'd3, 3'd0, 2, 32'h2468_ACE0);
      applyStimulus(1'b1, 32'h0000_3000, 32'h8765_4321, 3'd1, 3'd1, 0, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 32'h0000_3101, 32'h0000_BEEF, 3'd0, 3'd2, 0, 32'h0);
      applyStimulus(1'b1, 32'h0000_4000, 32'h0, 3'd5, 3'd0, 0, 32'h0);
      applyStimulus(1'b1, 32'h0000_4000, 32'h0, 3'd1, 3'd6, 0, 32'h0);
      applyStimulus(1'b0, 32'h0000_4000, 32'h0, 3'd1, 3'd0, 0, 32'h0);

      // Slave never answers
      applyStimulus(1'b1, 32'h0000_0400, 32'h0, 3'd1, 3'd0, -1, 32'h0);
      checkOutput("timeout_pulse_lit", 32'(toCnt), 32'd1);
      checkOutput("timeout_stall_lit", 32'(stallCnt), 32'd17);
      checkOutput("timeout_raw_lit", DM_RD_raw, 32'h2468_ACE0);

      // Reset while the request is outstanding
      Valid = 1'b1; Addr = 32'h300; DMReadEN = 3'd1; DMWriteEN = 3'd0;
      expStall = 1'b1;
      @(posedge clk); #1;
      Valid = 1'b0; DMReadEN = 3'd0;
      expReq = 1'b1; expWr = 1'b0; expAddr = 32'h300; expByteen = 4'b0; expWdata = 32'h0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOn = 1'b0;
      #1 reset = 1'b1;
      #1;
      checkOutput("rst_m_req", 32'(m_req), 32'h0);
      checkOutput("rst_stall", 32'(Stall), 32'h0);
      checkOutput("rst_timeout", 32'(Timeout), 32'h0);
      checkOutput("rst_raw", DM_RD_raw, 32'h0);
      modelRaw = 32'h0;
      setIdleExpect();
      @(posedge clk); #1;
      checkOn = 1'b1;
      reset = 1'b0;
      toCnt = 0;
      repeat (MAX_WAIT + 4) @(posedge clk);
      #1;
      checkOutput("rst_no_timeout", 32'(toCnt), 32'h0);

      // A read after reset still works
      applyStimulus(1'b1, 32'h0000_0500, 32'h0, 3'd1, 3'd0, 0, 32'h0F0F_0F0F);
      checkOutput("post_rst_raw_lit", DM_RD_raw, 32'h0F0F_0F0F);

      checkOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
